// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte-substitution tables and engine state encoding
package aes_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational single-byte forward/inverse AES S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in,
  input  logic       inverse,
  output logic [7:0] out
);
  assign out = inverse ? INV_SBOX[in] : SBOX[in];
endmodule

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative handshaked SubBytes/InvSubBytes, LANES bytes per cycle
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int K = 16 / LANES;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic mode;
  logic [127:0] work;
  logic [LANES*8-1:0] grp, sub;
  logic accept, last;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign busy = state == RUN;
  assign data_out = work;
  assign accept = in_valid && in_ready;
  assign last = cnt == CW'(K - 1);
  assign grp = work[int'(cnt) * LANES * 8 +: LANES * 8];
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    aes_sbox u_sbox (.in(grp[8*j +: 8]), .inverse(mode), .out(sub[8*j +: 8]));
  end
  // next state: a new accept always wins, so DONE with out_ready hands over without a bubble
  always_comb begin
    state_n = accept ? RUN : (state == RUN && last) ? DONE : (state == DONE && out_ready) ? IDLE : state;
  end
  // state, counter, latched mode and working state; work freezes outside RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mode <= 1'b0;
      work <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        work <= data_in;
        mode <= inverse;
        cnt <= '0;
      end else if (state == RUN) begin
        work[int'(cnt) * LANES * 8 +: LANES * 8] <= sub;
        cnt <= last ? '0 : cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: directed and swept checks of sub_bytes_iter against a GF(2^8) S-box model
module tb_sub_bytes_iter;
  localparam int NL = 5;
  localparam int LT [NL] = '{4, 1, 2, 8, 16};
  localparam int NRAND = 1000;
  localparam logic [127:0] PT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT = 128'h637c777bf26b6fc53001672bfed7ab76;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  int sweep_done = 0;
  bit tables_ok = 0;
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_state(logic [127:0] d, logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
    return r;
  endfunction

  // S-box built from its definition: multiplicative inverse in GF(2^8) followed by the affine map
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      logic [7:0] s;
      v = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
    tables_ok = 1;
  end

  for (genvar g = 0; g < NL; g++) begin : u
    localparam int K = 16 / LT[g];
    logic rst = 1, iv = 0, inv = 0, ordy = 0;
    logic [127:0] din = 0;
    logic ir, ov, busy;
    logic [127:0] dout;
    logic pend = 0, done = 0, fresh = 1, acc = 0;
    int rem = 0;
    logic [127:0] exp_q = 0;
    logic m_ready;
    assign m_ready = !pend || (done && ordy);
    sub_bytes_iter #(.LANES(LT[g])) dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .inverse(inv), .data_in(din),
      .out_valid(ov), .out_ready(ordy), .data_out(dout), .busy(busy)
    );
    // transaction model: a state is accepted, is busy for K edges, then waits for out_ready
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        pend <= 0; done <= 0; fresh <= 1; acc <= 0; rem <= 0;
      end else begin
        acc <= iv && m_ready;
        if (iv && m_ready) begin
          pend <= 1; done <= 0; rem <= K; fresh <= 0; exp_q <= sub_state(din, inv);
        end else if (done && ordy) begin
          pend <= 0; done <= 0;
        end else if (pend && !done) begin
          rem <= rem - 1;
          if (rem == 1) done <= 1;
        end
      end
    end
    // per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
      if (!rst && tables_ok) begin
        check($sformatf("L%0d in_ready", LT[g]), 128'(ir), 128'(m_ready));
        check($sformatf("L%0d out_valid", LT[g]), 128'(ov), 128'(done));
        check($sformatf("L%0d busy", LT[g]), 128'(busy), 128'(pend && !done));
        if (done) check($sformatf("L%0d data_out", LT[g]), dout, exp_q);
        if (fresh) check($sformatf("L%0d data_out after reset", LT[g]), dout, 128'h0);
      end
    end
    if (g > 0) begin : sw
      initial begin
        #3 rst = 0;
        wait (tables_ok);
        @(posedge clk); #1;
        ordy = 1;
        for (int n = 0; n < 2 * NRAND; n++) begin
          int t;
          t = 0;
          iv = 1;
          inv = n >= NRAND;
          din = {$urandom, $urandom, $urandom, $urandom};
          do begin @(posedge clk); #1; t++; end while (!acc && t < 40);
          check($sformatf("L%0d sweep accept", LT[g]), 128'(acc), 128'(1));
        end
        iv = 0;
        repeat (20) @(posedge clk);
        sweep_done++;
      end
    end
  end

  initial begin
    logic [127:0] r;
    wait (tables_ok);
    check("model S(53)", 128'(fwd_t[8'h53]), 128'hed);
    check("model invS(ED)", 128'(inv_t[8'hed]), 128'h53);
    check("model invS(63)", 128'(inv_t[8'h63]), 128'h00);
    check("model fwd vector", sub_state(PT, 0), CT);
    #3 u[0].rst = 0;
    @(negedge clk);
    check("reset in_ready", 128'(u[0].ir), 128'(1));
    check("reset out_valid", 128'(u[0].ov), 128'(0));
    check("reset busy", 128'(u[0].busy), 128'(0));
    check("reset data_out", u[0].dout, 128'h0);
    @(posedge clk); #1;
    u[0].iv = 1; u[0].din = PT; u[0].inv = 0; u[0].ordy = 0;
    @(posedge clk); #1;
    u[0].iv = 0;
    repeat (3) @(posedge clk);
    #1 check("fwd out_valid before latency", 128'(u[0].ov), 128'(0));
    @(posedge clk); #1;
    check("fwd out_valid at latency 4", 128'(u[0].ov), 128'(1));
    check("fwd data_out", u[0].dout, CT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("backpressure data_out", u[0].dout, CT);
      check("backpressure in_ready", 128'(u[0].ir), 128'(0));
    end
    u[0].ordy = 1; u[0].iv = 1; u[0].din = CT; u[0].inv = 1;
    #1 check("handover in_ready", 128'(u[0].ir), 128'(1));
    @(posedge clk); #1;
    u[0].iv = 0; u[0].ordy = 0;
    check("handover busy", 128'(u[0].busy), 128'(1));
    check("handover out_valid", 128'(u[0].ov), 128'(0));
    repeat (4) @(posedge clk);
    #1 check("inverse data_out", u[0].dout, PT);
    for (int m = 0; m < 2; m++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      u[0].ordy = 1; u[0].iv = 1; u[0].din = r; u[0].inv = m[0];
      @(posedge clk); #1;
      u[0].iv = 0; u[0].ordy = 0;
      for (int i = 0; i < 4; i++) begin
        u[0].inv = ~u[0].inv;
        @(posedge clk); #1;
      end
      check("mode latch data_out", u[0].dout, sub_state(r, m[0]));
    end
    u[0].ordy = 1; u[0].iv = 1; u[0].din = PT; u[0].inv = 0;
    @(posedge clk); #1;
    u[0].iv = 0;
    repeat (2) @(posedge clk);
    #3 u[0].rst = 1;
    #1;
    check("mid-run reset in_ready", 128'(u[0].ir), 128'(1));
    check("mid-run reset out_valid", 128'(u[0].ov), 128'(0));
    check("mid-run reset busy", 128'(u[0].busy), 128'(0));
    check("mid-run reset data_out", u[0].dout, 128'h0);
    #2 u[0].rst = 0;
    @(posedge clk); #1;
    u[0].iv = 1; u[0].din = 128'h0; u[0].inv = 0; u[0].ordy = 0;
    @(posedge clk); #1;
    u[0].iv = 0;
    repeat (4) @(posedge clk);
    #1 check("zeros after reset out_valid", 128'(u[0].ov), 128'(1));
    check("zeros after reset data_out", u[0].dout, {16{8'h63}});
    for (int n = 0; n < 30; n++) begin
      int t;
      t = 0;
      u[0].iv = 1; u[0].din = {$urandom, $urandom, $urandom, $urandom}; u[0].inv = 1'($urandom_range(1));
      do begin
        u[0].ordy = 1'($urandom_range(1));
        @(posedge clk); #1;
        t++;
      end while (!u[0].acc && t < 100);
      check("random accept", 128'(u[0].acc), 128'(1));
    end
    u[0].iv = 0; u[0].ordy = 1;
    for (int t = 0; t < 60000 && sweep_done < NL - 1; t++) @(posedge clk);
    check("sweep completion", 128'(sweep_done), 128'(NL - 1));
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative, handshaked AES SubBytes/InvSubBytes engine for one 128-bit state. It substitutes LANES bytes per clock and finishes a state in 16/LANES cycles, so area can be traded against throughput. It sits between the round-key XOR and ShiftRows stages of the round datapath. It replaces the purely combinational byte-substitution stage wherever area matters or a registered, flow-controlled stage is needed.

## Interface
- LANES, default 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Any other value must fail at elaboration.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in and inverse are valid this cycle.
- in_ready  output  1  engine can accept a state this cycle.
- inverse  input  1  0 = forward S-box, 1 = inverse S-box; sampled only at accept.
- data_in  input  128  input state; byte k = data_in[8k+7:8k].
- out_valid  output  1  data_out holds a completed state.
- out_ready  input  1  downstream consumes data_out this cycle.
- data_out  output  128  substituted state, same byte ordering as data_in.
- busy  output  1  high in RUN.

## Operation
- K = 16/LANES, the number of substitution cycles per state.
- States: IDLE, RUN, DONE.
- Internal registers:
  - work[127:0], the working state, drives data_out directly.
  - cnt, width clog2(K) with a minimum of 1 bit.
  - mode, the latched value of inverse.
- IDLE:
  - in_ready=1.
  - On in_valid: load work←data_in, mode←inverse, cnt←0, go to RUN.
- RUN:
  - Each cycle, bytes cnt·LANES … cnt·LANES+LANES−1 of work are replaced by S(byte) or S⁻¹(byte) according to mode. All other bytes hold.
  - cnt increments; when cnt=K−1 the update is made and the state goes to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; work is held stable until handshake.
  - When out_ready=1 and in_valid=0: go to IDLE.
  - When out_ready=1 and in_valid=1: in_ready=1 (combinational from out_ready) and the new state is loaded exactly as in IDLE, going straight to RUN with no bubble.
  - When out_ready=0: stay in DONE, in_ready=0, and data_out must not change.
- The inverse input is ignored outside an accept cycle. Toggling it during RUN has no effect.
- Bytes are processed in ascending order, starting with byte 0 = bits [7:0].

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, data_out=0, state IDLE, cnt=0.
- Reset asserted mid-RUN or in DONE aborts the state immediately; the partial result is discarded.
- Accept on edge N → byte groups update on edges N+1 … N+K → out_valid is high starting in the cycle after edge N+K.
- Latency is K cycles from accept to out_valid:
  - LANES=16 gives 1 cycle.
  - LANES=1 gives 16 cycles.
- Sustained throughput with out_ready held high is one state per K+1 cycles; the DONE cycle overlaps the next accept.
- in_ready and out_valid are never both high except in DONE when out_ready=1.
- data_out is don't-care while out_valid=0, except after reset, when it is 0.

## Structure
- Shared package aes_pkg holds:
  - SBOX[0:255] and INV_SBOX[0:255] as 8-bit constant arrays; the forward table matches the existing SubBytes mapping.
  - the state enum {IDLE, RUN, DONE}.
- Sub-module aes_sbox: combinational, one byte. Ports: in[7:0], inverse, out[7:0].
  - Instantiated LANES times.
  - Lane j reads work byte cnt·LANES+j.
- The top level contains only the FSM, the counter, the mode register and the work register, muxed by cnt.

## Test plan
- Forward vector, LANES=4: data_in=128'h000102030405060708090a0b0c0d0e0f, inverse=0 → out_valid exactly 4 cycles after accept, data_out=128'h637c777bf26b6fc53001672bfed7ab76.
- Inverse round-trip: feed 128'h637c777bf26b6fc53001672bfed7ab76 with inverse=1 → data_out=128'h000102030405060708090a0b0c0d0e0f. Also spot-check single bytes: S(53)=ED, S⁻¹(ED)=53, S⁻¹(63)=00.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → data_out stable, in_ready=0. Raise out_ready together with in_valid → the new state is accepted in the same cycle and RUN starts on the next edge.
- Mode latch: toggle inverse every cycle during RUN → result equals pure forward or pure inverse per the accept-cycle value.
- Reset mid-RUN: assert rst after 2 of 4 cycles → outputs return to their reset values asynchronously. The next accepted state all 00 gives all 63.
- Parameter sweep, LANES ∈ {1,2,8,16}: 1000 random states in each mode, compared against a reference model → latency is exactly 16/LANES and data matches.
